// File: rtl/fft_frame_sequencer.sv
// Run controller for the filter -> window -> FFT -> magnitude chain.
// Sequences filter completion, per-frame window copy, FFT execution and a valid/ready bin stream.
module fft_frame_sequencer #(
    parameter int DATA_W   = 32,
    parameter int F_ADDR_W = 10,
    parameter int WIN_LEN  = 64,
    parameter int HOP      = 32,
    parameter int TIMEOUT  = 2**27
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                filt_rst,
    input  logic                filt_done,
    output logic [F_ADDR_W-1:0] f_addr,
    input  logic [DATA_W-1:0]   f_dout,
    output logic [5:0]          w_addr,
    output logic                w_we,
    output logic [DATA_W-1:0]   w_din,
    output logic                fft_rst,
    input  logic                fft_done,
    output logic [5:0]          o_addr,
    input  logic [DATA_W-1:0]   o_dout,
    output logic [DATA_W-1:0]   mag,
    output logic [5:0]          mag_bin,
    output logic                mag_valid,
    input  logic                mag_ready,
    output logic [4:0]          frame_idx
);

    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int SPAN_W = F_ADDR_W + 2;
    localparam logic [6:0] K_END    = 7'(WIN_LEN);
    localparam logic [6:0] BIN_LAST = 7'(WIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILT, S_COPY, S_FFT, S_ISSUE, S_HOLD, S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [F_ADDR_W-1:0] base_q, base_d;
    logic [4:0]          frame_q, frame_d;
    logic [6:0]          k_q, k_d;
    logic [6:0]          bin_q, bin_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   mag_q, mag_d;
    logic [5:0]          mag_bin_q, mag_bin_d;
    logic                mag_valid_q, mag_valid_d;

    logic [SPAN_W-1:0]   span;
    logic                last_frame;
    logic                wd_hit;

    // A frame is the last one when the next window would run past the end of the RAM.
    assign span       = SPAN_W'(base_q) + SPAN_W'(HOP) + SPAN_W'(WIN_LEN);
    assign last_frame = span > SPAN_W'(1 << F_ADDR_W);
    assign wd_hit     = (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            frame_q     <= '0;
            k_q         <= '0;
            bin_q       <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            mag_q       <= '0;
            mag_bin_q   <= '0;
            mag_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            frame_q     <= frame_d;
            k_q         <= k_d;
            bin_q       <= bin_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            mag_q       <= mag_d;
            mag_bin_q   <= mag_bin_d;
            mag_valid_q <= mag_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        frame_d     = frame_q;
        k_d         = k_q;
        bin_d       = bin_q;
        wd_d        = wd_q;
        err_d       = err_q;
        mag_d       = mag_q;
        mag_bin_d   = mag_bin_q;
        mag_valid_d = mag_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    base_d  = '0;
                    frame_d = '0;
                    wd_d    = '0;
                    state_d = S_FILT;
                end
            end
            S_FILT: begin
                if (filt_done) begin
                    k_d     = '0;
                    state_d = S_COPY;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_COPY: begin
                if (k_q == K_END) begin
                    wd_d    = '0;
                    state_d = S_FFT;
                end else begin
                    k_d = k_q + 7'd1;
                end
            end
            S_FFT: begin
                if (fft_done) begin
                    bin_d   = '0;
                    state_d = S_ISSUE;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_ISSUE: state_d = S_HOLD;
            S_HOLD: begin
                // First HOLD cycle captures the RAM word; valid is raised from the next cycle.
                if (!mag_valid_q) begin
                    mag_d       = o_dout;
                    mag_bin_d   = 6'(bin_q);
                    mag_valid_d = 1'b1;
                end else if (mag_ready) begin
                    mag_valid_d = 1'b0;
                    if (bin_q < BIN_LAST) begin
                        bin_d   = bin_q + 7'd1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (last_frame) begin
                    state_d = S_IDLE;
                end else begin
                    base_d  = base_q + F_ADDR_W'(HOP);
                    frame_d = frame_q + 5'd1;
                    k_d     = '0;
                    state_d = S_COPY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition above, but never touches the sticky error.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            mag_valid_d = 1'b0;
            err_d       = err_q;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_NEXT) && last_frame && !abort;
    assign err       = err_q;
    assign filt_rst  = (state_q != S_FILT);
    assign fft_rst   = (state_q != S_FFT);
    assign f_addr    = ((state_q == S_COPY) && (k_q < K_END)) ? (base_q + F_ADDR_W'(k_q)) : '0;
    // RAM data lags the address by one cycle, so write k-1 while reading k.
    assign w_we      = (state_q == S_COPY) && (k_q != 7'd0) && !abort;
    assign w_addr    = w_we ? 6'(k_q - 7'd1) : 6'd0;
    assign w_din     = w_we ? f_dout : '0;
    assign o_addr    = 6'(bin_q);
    assign mag       = mag_q;
    assign mag_bin   = mag_bin_q;
    assign mag_valid = mag_valid_q;
    assign frame_idx = frame_q;

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

- Top-level controller for the filter → window → FFT → magnitude chain.
- Replaces fixed delay counts with handshakes: it holds the bandpass filter out of reset until `filt_done`, then steps a 64-sample window through the 1024-entry filtered-sample RAM with 32-sample hop.
- For each frame it copies the window into the window RAM, releases the FFT core until `fft_done`, then streams the 64 output-RAM magnitudes out on a valid/ready port.
- A watchdog flags a stalled core.

## Interface
Parameters:
- `DATA_W`, 32, sample/magnitude width
- `F_ADDR_W`, 10, filtered-sample RAM address width (depth 2^F_ADDR_W)
- `WIN_LEN`, 64, window length; window and output RAM depth
- `HOP`, 32, window advance per frame
- `TIMEOUT`, 2^27, watchdog limit in cycles for FILT and FFT_RUN

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle request to begin a run; honoured only in IDLE
- `abort` in 1: synchronous abandon of the current run
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse after the last frame's last bin is accepted
- `err` out 1: sticky watchdog flag; cleared by `start` or `rst`
- `filt_rst` out 1: filter reset (active-high)
- `filt_done` in 1: filter finished (level)
- `f_addr` out F_ADDR_W: filtered-sample RAM read address
- `f_dout` in DATA_W: filtered-sample RAM data, 1-cycle read latency
- `w_addr` out 6: window RAM write address
- `w_we` out 1: window RAM write enable
- `w_din` out DATA_W: window RAM write data
- `fft_rst` out 1: FFT core reset (active-high)
- `fft_done` in 1: FFT finished (level)
- `o_addr` out 6: output RAM read address
- `o_dout` in DATA_W: output RAM data, 1-cycle read latency
- `mag` out DATA_W: magnitude data
- `mag_bin` out 6: bin index of `mag`
- `mag_valid` out 1: magnitude handshake valid
- `mag_ready` in 1: magnitude handshake ready
- `frame_idx` out 5: index of the current frame

## Operation
**States:**
- **IDLE:** On `start`, clear `err`, base=0, frame_idx=0, go to FILT.
- **FILT:** `filt_rst`=0. On `filt_done`=1, go to COPY; `filt_rst` returns to 1 the same edge.
- **COPY:** Counter k=0..WIN_LEN.
  - For k<WIN_LEN: `f_addr`=base+k.
  - For k≥1: `w_we`=1, `w_addr`=k-1, `w_din`=`f_dout`.
  - After k=WIN_LEN, go to FFT_RUN.
- **FFT_RUN:** `fft_rst`=0. On `fft_done`=1, `fft_rst`=1 and go to RD_ISSUE with bin=0.
- **RD_ISSUE:** `o_addr`=bin; go to RD_HOLD next cycle.
- **RD_HOLD:**
  - The first cycle registers `o_dout` into `mag` and `bin` into `mag_bin`; `mag_valid`=1 from the next cycle.
  - Hold until `mag_valid`&`mag_ready`.
  - Then: if bin<WIN_LEN-1, bin+1 and go to RD_ISSUE; else go to NEXT.
- **NEXT:**
  - If base+HOP+WIN_LEN > 2^F_ADDR_W (last frame): pulse `done`, go to IDLE.
  - Else base+=HOP, frame_idx+1, go to COPY.
  - With defaults: 31 frames, bases 0..960 step 32.

**Watchdog:**
- The counter clears on entry to FILT or FFT_RUN.
- On reaching TIMEOUT: set `err`, force `filt_rst`=`fft_rst`=1, go to IDLE, no `done`.

**abort:**
- Legal in any non-IDLE state.
- Next state is IDLE; `filt_rst`=`fft_rst`=1, `mag_valid`=0, `w_we`=0, no `done`, `err` unchanged.
- `abort` takes priority over every same-cycle transition, including `done`.

**Arithmetic and widths:**
- base/address arithmetic is F_ADDR_W bits; no wrap is reachable because of the NEXT check.
- bin and k use 7-bit counters so the terminal compare is exact.

## Timing
**Reset values:**
- `filt_rst`=`fft_rst`=1.
- `busy`, `done`, `err`, `w_we`, `mag_valid`=0.
- All addresses, `mag`, `mag_bin`, `frame_idx`=0.
- State = IDLE.

**Latencies:**
- `start` to `filt_rst` low: 1 cycle.
- COPY: exactly WIN_LEN+1 cycles; 64 writes, addresses 0..63 contiguous.
- Per bin with `mag_ready` held high: 3 cycles (ISSUE, HOLD-load, HOLD-valid).

**Handshake rules:**
- `mag`/`mag_bin` are stable while `mag_valid`=1 and `mag_ready`=0.
- `mag_valid` drops the cycle after acceptance.

**Boundary conditions:**
- `start` while busy: ignored.
- `filt_done` or `fft_done` already high on state entry: advance after 1 cycle.
- `fft_done` outside FFT_RUN: ignored.
- `rst` asserted mid-frame: immediate reset values, no partial `done`.

## Test plan
- **Nominal run:** `filt_done` after 100 cycles; `fft_done` 200 cycles after each `fft_rst` fall; `mag_ready`=1 → 31 frames × 64 bins accepted in order; `f_addr` range of frame 1 is 32..95; one `done`; `err`=0.
- **Window copy check:** preload f RAM[i]=i → frame 3 writes `w_din` 96..159 at `w_addr` 0..63, one write per cycle, 65 cycles in COPY.
- **Backpressure:** `mag_ready` toggles 1/0 randomly → `mag`/`mag_bin` never change while stalled; 64 unique bins per frame; no loss or duplication.
- **Watchdog:** `fft_done` never asserted with TIMEOUT=1000 → `err`=1 at cycle 1000 of FFT_RUN, `fft_rst`=1, IDLE; next `start` clears `err`.
- **abort/rst mid-operation:** `abort` during frame 5 RD_HOLD → IDLE next cycle, `mag_valid`=0, no `done`; repeat with async `rst` mid-COPY → outputs at reset values before the next edge.
- **start while busy:** `start` pulsed during FILT and COPY → no restart; `frame_idx` and `f_addr` progression are unchanged.
